// File: rtl/counter_arbiter_if.sv
// Requester-side bundle for counter_arbiter: requests with delays in, grants,
// completion pulses and counter state out.
interface counter_arbiter_if #(
  parameter int NUM_REQ     = 4,
  parameter int COUNT_WIDTH = 8
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]             req;
  logic [NUM_REQ*COUNT_WIDTH-1:0] req_delay;
  logic [NUM_REQ-1:0]             gnt;
  logic [ID_W-1:0]                gnt_id;
  logic [NUM_REQ-1:0]             done;
  logic                           busy;
  logic [COUNT_WIDTH-1:0]         count;

  modport master (
    output req, req_delay,
    input  gnt, gnt_id, done, busy, count
  );

  modport slave (
    input  req, req_delay,
    output gnt, gnt_id, done, busy, count
  );
endinterface

// File: rtl/counter_arbiter.sv
// Shares one 0..D delay counter among NUM_REQ requesters (IDLE/RUN/DONE FSM).
// Define COUNTER_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module counter_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int COUNT_WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  counter_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [COUNT_WIDTH-1:0] target_q, target_d;
  logic [ID_W-1:0]        gnt_id_q, gnt_id_d;
  logic [ID_W-1:0]        winner, cand;
  logic                   found;
  logic [COUNT_WIDTH-1:0] delay_arr [NUM_REQ];

`ifndef COUNTER_ARB_FIXED_PRIO_EN
  logic [ID_W-1:0]        ptr_q, ptr_d;
`endif

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign delay_arr[g] = bus.req_delay[g*COUNT_WIDTH +: COUNT_WIDTH];
  end

  always_comb begin
    winner = '0;
    cand   = '0;
    found  = 1'b0;
`ifdef COUNTER_ARB_FIXED_PRIO_EN
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ID_W'(i);
      if (!found && bus.req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
`else
    // Search starts just after the last granted index and wraps.
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = ID_W'((int'(ptr_q) + i) % NUM_REQ);
      if (!found && bus.req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
`endif
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    target_d = target_q;
    gnt_id_d = gnt_id_q;
`ifndef COUNTER_ARB_FIXED_PRIO_EN
    ptr_d    = ptr_q;
`endif
    unique case (state_q)
      IDLE: begin
        count_d = '0;
        if (found) begin
          state_d  = RUN;
          target_d = delay_arr[winner];
          gnt_id_d = winner;
`ifndef COUNTER_ARB_FIXED_PRIO_EN
          ptr_d    = winner;
`endif
        end
      end
      RUN: begin
        // A dropped request beats reaching the target: no done on abort.
        if (!bus.req[gnt_id_q]) begin
          state_d = IDLE;
          count_d = '0;
        end else if (count_q == target_q) begin
          state_d = DONE;
        end else begin
          count_d = count_q + COUNT_WIDTH'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
        count_d = '0;
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      count_q  <= '0;
      gnt_id_q <= '0;
`ifndef COUNTER_ARB_FIXED_PRIO_EN
      ptr_q    <= ID_W'(NUM_REQ - 1);
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      gnt_id_q <= gnt_id_d;
`ifndef COUNTER_ARB_FIXED_PRIO_EN
      ptr_q    <= ptr_d;
`endif
    end
  end

  // Target is only read in RUN, after it has been loaded at grant.
  always_ff @(posedge clk) begin
    target_q <= target_d;
  end

  assign bus.busy   = (state_q != IDLE);
  assign bus.gnt    = bus.busy ? (NUM_REQ'(1) << gnt_id_q) : '0;
  assign bus.done   = (state_q == DONE) ? (NUM_REQ'(1) << gnt_id_q) : '0;
  assign bus.gnt_id = gnt_id_q;
  assign bus.count  = count_q;

endmodule

// File: tb/tb_counter_arbiter.sv
// Randomized self-checking bench for counter_arbiter against a transaction-level
// model: arbitration by index arithmetic, timing by cycle offsets from the grant edge.
module tb_counter_arbiter;
  localparam int N = 4;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;

  counter_arbiter_if #(.NUM_REQ(N), .COUNT_WIDTH(W)) bus ();

  counter_arbiter #(.NUM_REQ(N), .COUNT_WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [N-1:0] req_v;
  logic [W-1:0] delay_v [N];
  int           last_g;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic drive();
    bus.req = req_v;
    for (int i = 0; i < N; i++) bus.req_delay[i*W +: W] = delay_v[i];
  endtask

  function automatic int pick(input logic [N-1:0] r, input int last);
    int j;
`ifdef COUNTER_ARB_FIXED_PRIO_EN
    for (int i = 0; i < N; i++) begin
      if (((r >> i) & 1) != 0) return i;
    end
`else
    for (int i = 1; i <= N; i++) begin
      j = (last + i) % N;
      if (((r >> j) & 1) != 0) return j;
    end
`endif
    return -1;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_gnt"},   32'(bus.gnt),   0);
    check({tag, "_busy"},  32'(bus.busy),  0);
    check({tag, "_done"},  32'(bus.done),  0);
    check({tag, "_count"}, 32'(bus.count), 0);
  endtask

  // Called at a negedge in an IDLE cycle with req_v nonzero; returns at a
  // negedge in the IDLE cycle after the grant ends.
  task automatic run_txn(input int abort_at);
    int w;
    int d;
    logic [N-1:0] g;
    if (req_v == '0) req_v[0] = 1'b1;
    drive();
    w = pick(req_v, last_g);
    d = int'(delay_v[w]);
    last_g = w;
    g = N'(1) << w;
    @(negedge clk);
    check("grant_gnt",    32'(bus.gnt),    32'(g));
    check("grant_id",     32'(bus.gnt_id), 32'(w));
    check("grant_busy",   32'(bus.busy),   1);
    check("grant_count",  32'(bus.count),  0);
    check("grant_done",   32'(bus.done),   0);
    for (int k = 0; k <= d; k++) begin
      if (k > 0) begin
        @(negedge clk);
        check("run_count", 32'(bus.count), 32'(k));
        check("run_gnt",   32'(bus.gnt),   32'(g));
        check("run_done",  32'(bus.done),  0);
      end
      for (int i = 0; i < N; i++) delay_v[i] = W'($urandom_range(0, 255));
      drive();
      if (k == abort_at) begin
        req_v[w] = 1'b0;
        drive();
        @(negedge clk);
        check_idle("abort");
        return;
      end
    end
    @(negedge clk);
    check("done_pulse", 32'(bus.done),  32'(g));
    check("done_gnt",   32'(bus.gnt),   32'(g));
    check("done_busy",  32'(bus.busy),  1);
    check("done_count", 32'(bus.count), 32'(d));
    req_v[w] = 1'b0;
    drive();
    @(negedge clk);
    check_idle("release");
  endtask

  initial begin
    req_v  = '0;
    for (int i = 0; i < N; i++) delay_v[i] = '0;
    last_g = N - 1;
    drive();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_idle("reset");
    check("reset_id", 32'(bus.gnt_id), 0);
    rst = 1'b0;
    @(negedge clk);
    check_idle("post_reset");

    req_v = 4'b0001; delay_v[0] = 8'd5;
    run_txn(-1);

    req_v = 4'b0100; delay_v[2] = 8'd0;
    run_txn(-1);

    // Asynchronous reset in the middle of a run at count 3.
    req_v = 4'b0001; delay_v[0] = 8'd10;
    drive();
    repeat (4) @(negedge clk);
    check("pre_rst_count", 32'(bus.count), 3);
    #2 rst = 1'b1;
    #1;
    check_idle("async_rst");
    check("async_rst_id", 32'(bus.gnt_id), 0);
    @(negedge clk);
    rst = 1'b0;
    req_v = '0;
    drive();
    last_g = N - 1;
    repeat (2) @(negedge clk);
    check_idle("rst_idle");

    req_v = 4'b1111;
    for (int i = 0; i < N; i++) delay_v[i] = 8'd2;
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < N; i++) delay_v[i] = 8'd2;
      run_txn(-1);
    end
    req_v = 4'b1111;
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < N; i++) delay_v[i] = 8'd2;
      run_txn(-1);
    end
    req_v[0] = 1'b1;
    for (int i = 0; i < N; i++) delay_v[i] = 8'd2;
    run_txn(-1);

    // Abort of requester 1 with requester 2 pending.
    req_v = '0;
    drive();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    last_g = N - 1;
    req_v = 4'b0110;
    for (int i = 0; i < N; i++) delay_v[i] = 8'd10;
    run_txn(4);
    for (int i = 0; i < N; i++) delay_v[i] = 8'd3;
    run_txn(-1);

    req_v = 4'b0001; delay_v[0] = 8'd255;
    run_txn(-1);

    for (int t = 0; t < 40; t++) begin
      int abort_at;
      if ($urandom_range(0, 4) == 0) begin
        req_v = '0;
        drive();
        repeat (2) @(negedge clk);
        check_idle("rand_idle");
      end
      req_v = req_v | N'($urandom_range(0, 15));
      if (req_v == '0) req_v[$urandom_range(0, N-1)] = 1'b1;
      for (int i = 0; i < N; i++) delay_v[i] = W'($urandom_range(0, 12));
      abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : -1;
      run_txn(abort_at);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
